// File: rtl/four_bank_mem_pkg.sv
// Shared constants for the four-way interleaved memory model.
// Bank select, busy window and read-pipeline depth live here.
package four_bank_mem_pkg;

    localparam int NUM_BANKS        = 4;
    localparam int BANK_SEL_LSB     = 1;
    localparam int BANK_SEL_W       = 2;
    localparam int BANK_BUSY_CYCLES = 4;
    localparam int READ_LATENCY     = 2;
    localparam int BANK_CNT_W       = 2;

    // Busy for cycles t+1..t+3, free again at t+4.
    localparam logic [BANK_CNT_W-1:0] BANK_CNT_LOAD =
        BANK_CNT_W'(BANK_BUSY_CYCLES - 1);

endpackage

// File: rtl/four_bank_mem_bank_timer.sv
// Per-bank occupancy timer: loadable down-counter and busy flag.
// busy is a pure function of the counter register.
module bank_timer
    import four_bank_mem_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic busy
);

    logic [BANK_CNT_W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= BANK_CNT_LOAD;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign busy = |cnt;

endmodule

// File: rtl/four_bank_mem.sv
// Four-way word-interleaved main memory with per-bank busy timers.
// Optional FOUR_BANK_ALIGN_CHECK_EN rejects odd byte addresses.
module four_bank_mem
    import four_bank_mem_pkg::*;
#(
    parameter int MEM_ADDR_W = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [MEM_ADDR_W-1:0] addr,
    input  logic [15:0]           data_in,
    input  logic                  wr,
    input  logic                  rd,
    output logic [15:0]           data_out,
    output logic                  data_valid,
    output logic                  stall,
    output logic [NUM_BANKS-1:0]  busy,
    output logic                  err
);

    localparam int WORDS = 2 ** (MEM_ADDR_W - 1);

    logic [BANK_SEL_W-1:0] bank;
    logic [MEM_ADDR_W-2:0] widx;
    logic                  req;
    logic                  conflict;
    logic                  misaligned;
    logic                  accept;
    logic                  rd_acc;
    logic                  wr_acc;

    assign bank     = addr[BANK_SEL_LSB +: BANK_SEL_W];
    assign widx     = addr[MEM_ADDR_W-1:1];
    assign req      = rd | wr;
    assign conflict = rd & wr;

`ifdef FOUR_BANK_ALIGN_CHECK_EN
    assign misaligned = addr[0];
`else
    logic unused_addr_lsb;
    assign unused_addr_lsb = addr[0];
    assign misaligned      = 1'b0;
`endif

    assign err    = req & (conflict | misaligned);
    assign stall  = req & (busy[bank] | err);
    assign accept = req & ~stall;
    // err excludes rd&wr, so an accept is exactly one of the two
    assign rd_acc = accept & rd;
    assign wr_acc = accept & wr;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic load;
        assign load = accept & (bank == BANK_SEL_W'(b));

        bank_timer u_timer (
            .clk  (clk),
            .rst  (rst),
            .load (load),
            .busy (busy[b])
        );
    end

    logic [15:0] mem [WORDS];

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[widx] <= data_in;
        end
    end

    logic [READ_LATENCY-1:0] vld;
    logic [15:0]             pdata [READ_LATENCY-1];

    always_ff @(posedge clk) begin
        if (rd_acc) begin
            pdata[0] <= mem[widx];
        end
        for (int i = 1; i < READ_LATENCY - 1; i++) begin
            pdata[i] <= pdata[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld      <= '0;
            data_out <= 16'h0000;
        end else begin
            vld <= {vld[READ_LATENCY-2:0], rd_acc};
            if (vld[READ_LATENCY-2]) begin
                data_out <= pdata[READ_LATENCY-2];
            end
        end
    end

    assign data_valid = vld[READ_LATENCY-1];

endmodule

// File: tb/tb_four_bank_mem.sv
// Scoreboard bench for four_bank_mem: directed requests push expected
// read data and return cycle; a negedge monitor pops on data_valid.
module tb_four_bank_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] data_in;
    logic        wr;
    logic        rd;
    logic [15:0] data_out;
    logic        data_valid;
    logic        stall;
    logic [3:0]  busy;
    logic        err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    typedef struct {
        logic [15:0] data;
        int          at;
    } exp_t;

    exp_t sb[$];

    four_bank_mem dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .data_in    (data_in),
        .wr         (wr),
        .rd         (rd),
        .data_out   (data_out),
        .data_valid (data_valid),
        .stall      (stall),
        .busy       (busy),
        .err        (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h required %h (cycle %0d)",
                     name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (data_valid === 1'b1) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_valid: got data_out=%h at cycle %0d, required no data_valid",
                         data_out, cyc);
            end else begin
                e = sb.pop_front();
                if (data_out !== e.data || cyc != e.at) begin
                    failures++;
                    $display("FAIL read_data: got %h at cycle %0d, required %h at cycle %0d",
                             data_out, cyc, e.data, e.at);
                end
            end
        end
    end

    task automatic idle(input int n);
        rd = 1'b0;
        wr = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Holds the request until stall drops; acc is the accepting cycle.
    task automatic issue(input logic r, input logic w,
                         input logic [15:0] a, input logic [15:0] d,
                         output int acc);
        rd      = r;
        wr      = w;
        addr    = a;
        data_in = d;
        acc     = -1;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (stall === 1'b0) begin
                acc = cyc;
                break;
            end
            @(posedge clk);
            #1;
        end
        if (acc < 0) begin
            checks++;
            failures++;
            $display("FAIL accept_timeout: got stall for 16 cycles at addr %h, required acceptance", a);
        end
        @(posedge clk);
        #1;
        rd = 1'b0;
        wr = 1'b0;
    endtask

    task automatic expect_read(input logic [15:0] d, input int acc);
        exp_t e;
        e.data = d;
        e.at   = acc + 2;
        sb.push_back(e);
    endtask

    initial begin
        int a0, a1, a2, a3, wa, ra;
        logic [15:0] fill [4];
        fill[0] = 16'h1111;
        fill[1] = 16'h2222;
        fill[2] = 16'h3333;
        fill[3] = 16'h4444;

        rst = 1'b1; rd = 1'b0; wr = 1'b0; addr = '0; data_in = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_valid", 32'(data_valid), 32'h0);
        check("reset_data_out", 32'(data_out), 32'h0);
        check("reset_stall", 32'(stall), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        @(posedge clk);
        #1;

        issue(1'b0, 1'b1, 16'h0000, fill[0], a0);
        issue(1'b0, 1'b1, 16'h0002, fill[1], a1);
        issue(1'b0, 1'b1, 16'h0004, fill[2], a2);
        issue(1'b0, 1'b1, 16'h0006, fill[3], a3);
        check("preload_stream", 32'(a3 - a0), 32'd3);
        issue(1'b0, 1'b1, 16'h0008, 16'h5555, wa);
        check("preload_bank0_reuse", 32'(wa - a0), 32'd4);
        idle(4);

        issue(1'b0, 1'b1, 16'h0010, 16'hBEEF, wa);
        issue(1'b1, 1'b0, 16'h0010, 16'h0000, ra);
        check("raw_accept_delay", 32'(ra - wa), 32'd4);
        expect_read(16'hBEEF, ra);
        idle(6);
        check("data_out_hold", 32'(data_out), 32'hBEEF);

        issue(1'b1, 1'b0, 16'h0000, 16'h0, a0);
        expect_read(fill[0], a0);
        issue(1'b1, 1'b0, 16'h0002, 16'h0, a1);
        expect_read(fill[1], a1);
        issue(1'b1, 1'b0, 16'h0004, 16'h0, a2);
        expect_read(fill[2], a2);
        issue(1'b1, 1'b0, 16'h0006, 16'h0, a3);
        expect_read(fill[3], a3);
        check("fill_no_stall_1", 32'(a1 - a0), 32'd1);
        check("fill_no_stall_3", 32'(a3 - a0), 32'd3);
        idle(6);

        rd = 1'b1; wr = 1'b1; addr = 16'h0008; data_in = 16'hDEAD;
        @(negedge clk);
        check("conflict_err", 32'(err), 32'h1);
        check("conflict_stall", 32'(stall), 32'h1);
        @(posedge clk);
        #1 rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        check("conflict_busy", 32'(busy), 32'h0);
        idle(2);
        issue(1'b1, 1'b0, 16'h0008, 16'h0, ra);
        expect_read(16'h5555, ra);
        idle(6);

        issue(1'b0, 1'b1, 16'h000C, 16'h7777, wa);
        issue(1'b1, 1'b0, 16'h000A, 16'h0, ra);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_read_dropped", 32'(data_valid), 32'h0);
        check("rst_busy_clear", 32'(busy), 32'h0);
        check("rst_data_out", 32'(data_out), 32'h0);
        idle(3);
        issue(1'b1, 1'b0, 16'h000C, 16'h0, ra);
        expect_read(16'h7777, ra);
        idle(6);

`ifdef FOUR_BANK_ALIGN_CHECK_EN
        rd = 1'b1; addr = 16'h0003;
        @(negedge clk);
        check("unaligned_err", 32'(err), 32'h1);
        check("unaligned_stall", 32'(stall), 32'h1);
        @(posedge clk);
        #1 rd = 1'b0;
        @(negedge clk);
        check("unaligned_busy", 32'(busy), 32'h0);
        idle(4);
`else
        rd = 1'b1; addr = 16'h0003;
        @(negedge clk);
        check("unaligned_err", 32'(err), 32'h0);
        @(posedge clk);
        #1 rd = 1'b0;
        ra = cyc - 1;
        expect_read(fill[1], ra);
        idle(6);
`endif

        check("scoreboard_empty", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
